// File: rtl/triangle_assemble.sv
// Triangle setup: groups rasterized vertices into triangles, computes a screen-clipped bbox and
// twice the signed area, culls, and queues survivors in a FIFO. Optional macro: BACKFACE_CULL_EN.
module triangle_assemble #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [38:0]        rast_pt,
    input  logic               rast_pt_valid,
    input  logic               prim_restart,
    input  logic [11:0]        screen_w,
    input  logic [11:0]        screen_h,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [38:0]        tri_v0,
    output logic [38:0]        tri_v1,
    output logic [38:0]        tri_v2,
    output logic [11:0]        tri_bb_min_x,
    output logic [11:0]        tri_bb_min_y,
    output logic [11:0]        tri_bb_max_x,
    output logic [11:0]        tri_bb_max_y,
    output logic signed [27:0] tri_area2,
    output logic               tri_drop,
    output logic [CNT_W-1:0]   cull_count,
    output logic [CNT_W-1:0]   drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [38:0] v0;
        logic [38:0] v1;
        logic [38:0] v2;
        logic [11:0] min_x;
        logic [11:0] min_y;
        logic [11:0] max_x;
        logic [11:0] max_y;
        logic [27:0] area2;
    } tri_entry_t;

    function automatic logic signed [13:0] sx14(input logic [12:0] a);
        return $signed({a[12], a});
    endfunction

    function automatic logic signed [27:0] sx28(input logic [13:0] a);
        return $signed({{14{a[13]}}, a});
    endfunction

    function automatic logic signed [12:0] smin(input logic signed [12:0] a, input logic signed [12:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [12:0] smax(input logic signed [12:0] a, input logic signed [12:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- vertex assembly ----------------
    logic [1:0]  idx_q;
    logic [38:0] slot0_q, slot1_q;
    logic        asm_valid_q;
    logic [38:0] asm_v_q [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 2'd0;
            asm_valid_q <= 1'b0;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            asm_valid_q <= 1'b0;
            if (prim_restart) begin
                // A vertex arriving with the restart starts the new primitive.
                idx_q <= rast_pt_valid ? 2'd1 : 2'd0;
                if (rast_pt_valid) slot0_q <= rast_pt;
            end else if (rast_pt_valid) begin
                case (idx_q)
                    2'd0: begin
                        slot0_q <= rast_pt;
                        idx_q   <= 2'd1;
                    end
                    2'd1: begin
                        slot1_q <= rast_pt;
                        idx_q   <= 2'd2;
                    end
                    default: begin
                        asm_valid_q <= 1'b1;
                        idx_q       <= 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!prim_restart && rast_pt_valid && idx_q == 2'd2) begin
            asm_v_q[0] <= slot0_q;
            asm_v_q[1] <= slot1_q;
            asm_v_q[2] <= rast_pt;
        end
    end

    // ---------------- S1: edge vectors and raw extents ----------------
    logic signed [12:0] px [3];
    logic signed [12:0] py [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign px[gi] = asm_v_q[gi][12:0];
            assign py[gi] = asm_v_q[gi][25:13];
        end
    endgenerate

    logic               s1_valid_q;
    logic [38:0]        s1_v_q [3];
    logic signed [13:0] s1_dx1_q, s1_dy1_q, s1_dx2_q, s1_dy2_q;
    logic signed [12:0] s1_minx_q, s1_maxx_q, s1_miny_q, s1_maxy_q;

    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else     s1_valid_q <= asm_valid_q;
    end

    always_ff @(posedge clk) begin
        s1_v_q    <= asm_v_q;
        s1_dx1_q  <= sx14(px[1]) - sx14(px[0]);
        s1_dy1_q  <= sx14(py[1]) - sx14(py[0]);
        s1_dx2_q  <= sx14(px[2]) - sx14(px[0]);
        s1_dy2_q  <= sx14(py[2]) - sx14(py[0]);
        s1_minx_q <= smin(smin(px[0], px[1]), px[2]);
        s1_maxx_q <= smax(smax(px[0], px[1]), px[2]);
        s1_miny_q <= smin(smin(py[0], py[1]), py[2]);
        s1_maxy_q <= smax(smax(py[0], py[1]), py[2]);
    end

    // ---------------- S2: area, clip, cull ----------------
    logic signed [27:0] area_d;
    logic signed [13:0] dimx_m1, dimy_m1, cminx, cmaxx, cminy, cmaxy;
    logic               neg_w, cull_d;
    tri_entry_t         s2_entry_d;

    always_comb begin
        area_d  = sx28(s1_dx1_q) * sx28(s1_dy2_q) - sx28(s1_dx2_q) * sx28(s1_dy1_q);
        dimx_m1 = $signed({2'b00, screen_w}) - 14'sd1;
        dimy_m1 = $signed({2'b00, screen_h}) - 14'sd1;
        cminx   = s1_minx_q[12] ? 14'sd0 : sx14(s1_minx_q);
        cminy   = s1_miny_q[12] ? 14'sd0 : sx14(s1_miny_q);
        cmaxx   = (sx14(s1_maxx_q) > dimx_m1) ? dimx_m1 : sx14(s1_maxx_q);
        cmaxy   = (sx14(s1_maxy_q) > dimy_m1) ? dimy_m1 : sx14(s1_maxy_q);
        neg_w   = area_d[27];
        cull_d  = (area_d == 28'sd0) || (cminx > cmaxx) || (cminy > cmaxy);
`ifdef BACKFACE_CULL_EN
        cull_d  = cull_d || neg_w;
`endif
        // Negative winding is flipped so the consumer always sees positive area.
        s2_entry_d.v0    = s1_v_q[0];
        s2_entry_d.v1    = neg_w ? s1_v_q[2] : s1_v_q[1];
        s2_entry_d.v2    = neg_w ? s1_v_q[1] : s1_v_q[2];
        s2_entry_d.min_x = cminx[11:0];
        s2_entry_d.min_y = cminy[11:0];
        s2_entry_d.max_x = cmaxx[11:0];
        s2_entry_d.max_y = cmaxy[11:0];
        s2_entry_d.area2 = neg_w ? -area_d : area_d;
    end

    logic       s2_valid_q, s2_cull_q;
    tri_entry_t s2_entry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_cull_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_cull_q  <= cull_d;
        end
    end

    always_ff @(posedge clk) begin
        s2_entry_q <= s2_entry_d;
    end

    // ---------------- output FIFO and counters ----------------
    tri_entry_t     mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q, fill_w;
    logic           full_w, pop_w, push_w, drop_w, cull_w;
    logic           tri_drop_q;
    logic [CNT_W-1:0] cull_cnt_q, drop_cnt_q;

    assign fill_w    = wr_ptr_q - rd_ptr_q;
    assign full_w    = (fill_w == (PTR_W+1)'(FIFO_DEPTH));
    assign tri_valid = (wr_ptr_q != rd_ptr_q);
    assign pop_w     = tri_valid && tri_ready;
    assign cull_w    = s2_valid_q && s2_cull_q;
    // A same-cycle pop frees the slot before the enqueue is judged.
    assign push_w    = s2_valid_q && !s2_cull_q && (!full_w || pop_w);
    assign drop_w    = s2_valid_q && !s2_cull_q && full_w && !pop_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tri_drop_q <= 1'b0;
            cull_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            tri_drop_q <= drop_w;
            if (cull_w && cull_cnt_q != '1) cull_cnt_q <= cull_cnt_q + 1'b1;
            if (drop_w && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_ptr_q[PTR_W-1:0]] <= s2_entry_q;
    end

    tri_entry_t head_w;
    assign head_w = tri_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;

    assign tri_v0       = head_w.v0;
    assign tri_v1       = head_w.v1;
    assign tri_v2       = head_w.v2;
    assign tri_bb_min_x = head_w.min_x;
    assign tri_bb_min_y = head_w.min_y;
    assign tri_bb_max_x = head_w.max_x;
    assign tri_bb_max_y = head_w.max_y;
    assign tri_area2    = $signed(head_w.area2);
    assign tri_drop     = tri_drop_q;
    assign cull_count   = cull_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_triangle_assemble.sv
// Bench for triangle_assemble: directed scenarios plus randomized vertex streams checked every
// cycle against a queue-based model of assembly, setup arithmetic, culling and FIFO occupancy.
`timescale 1ns/1ps
module tb_triangle_assemble;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
`ifdef BACKFACE_CULL_EN
    localparam int BF = 1;
`else
    localparam int BF = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [38:0]        rast_pt = '0;
    logic               rast_pt_valid = 1'b0;
    logic               prim_restart = 1'b0;
    logic               tri_ready = 1'b0;
    logic [11:0]        screen_w = 12'd64;
    logic [11:0]        screen_h = 12'd64;
    logic               tri_valid, tri_drop;
    logic [38:0]        tri_v0, tri_v1, tri_v2;
    logic [11:0]        tri_bb_min_x, tri_bb_min_y, tri_bb_max_x, tri_bb_max_y;
    logic signed [27:0] tri_area2;
    logic [CW-1:0]      cull_count, drop_count;

    always #5 clk = ~clk;

    triangle_assemble #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rast_pt(rast_pt), .rast_pt_valid(rast_pt_valid),
        .prim_restart(prim_restart), .screen_w(screen_w), .screen_h(screen_h),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
        .tri_bb_min_x(tri_bb_min_x), .tri_bb_min_y(tri_bb_min_y),
        .tri_bb_max_x(tri_bb_max_x), .tri_bb_max_y(tri_bb_max_y),
        .tri_area2(tri_area2), .tri_drop(tri_drop),
        .cull_count(cull_count), .drop_count(drop_count)
    );

    typedef struct {
        logic [38:0] v0, v1, v2;
        int bx0, by0, bx1, by1, area;
        bit cull;
        int due;
    } tri_t;

    tri_t        mq[$];
    tri_t        pq[$];
    int          edge_no = 0;
    int          m_idx = 0;
    int          m_cull = 0;
    int          m_drop = 0;
    bit          m_drop_pulse = 1'b0;
    logic [38:0] m_v0 = '0, m_v1 = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [38:0] vtx(int x, int y, int z);
        return {13'(z), 13'(y), 13'(x)};
    endfunction

    function automatic tri_t make_tri(logic [38:0] a, logic [38:0] b, logic [38:0] c);
        tri_t t;
        int x0, y0, x1, y1, x2, y2, mnx, mxx, mny, mxy, wm1, hm1;
        x0 = $signed(a[12:0]); y0 = $signed(a[25:13]);
        x1 = $signed(b[12:0]); y1 = $signed(b[25:13]);
        x2 = $signed(c[12:0]); y2 = $signed(c[25:13]);
        t.area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
        mnx = x0; mxx = x0; mny = y0; mxy = y0;
        if (x1 < mnx) mnx = x1;
        if (x2 < mnx) mnx = x2;
        if (x1 > mxx) mxx = x1;
        if (x2 > mxx) mxx = x2;
        if (y1 < mny) mny = y1;
        if (y2 < mny) mny = y2;
        if (y1 > mxy) mxy = y1;
        if (y2 > mxy) mxy = y2;
        wm1 = int'(screen_w) - 1;
        hm1 = int'(screen_h) - 1;
        t.bx0 = (mnx < 0) ? 0 : mnx;
        t.by0 = (mny < 0) ? 0 : mny;
        t.bx1 = (mxx > wm1) ? wm1 : mxx;
        t.by1 = (mxy > hm1) ? hm1 : mxy;
        t.cull = (t.area == 0) || (t.bx0 > t.bx1) || (t.by0 > t.by1);
        if (BF == 1 && t.area < 0) t.cull = 1'b1;
        t.v0 = a;
        if (t.area < 0) begin
            t.v1 = c; t.v2 = b; t.area = -t.area;
        end else begin
            t.v1 = b; t.v2 = c;
        end
        t.due = edge_no + 3;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outputs();
        chk("tri_valid", tri_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("tri_v0", tri_v0, mq[0].v0);
            chk("tri_v1", tri_v1, mq[0].v1);
            chk("tri_v2", tri_v2, mq[0].v2);
            chk("bb_min_x", tri_bb_min_x, mq[0].bx0);
            chk("bb_min_y", tri_bb_min_y, mq[0].by0);
            chk("bb_max_x", tri_bb_max_x, mq[0].bx1);
            chk("bb_max_y", tri_bb_max_y, mq[0].by1);
            chk("area2", tri_area2, mq[0].area);
        end
        chk("tri_drop", tri_drop, m_drop_pulse);
        chk("cull_count", cull_count, m_cull);
        chk("drop_count", drop_count, m_drop);
    endtask

    task automatic model_step(input bit vld, input logic [38:0] pt, input bit rs, input bit rdy);
        tri_t t;
        edge_no++;
        m_drop_pulse = 1'b0;
        if (rdy && mq.size() > 0) mq.delete(0);
        if (pq.size() > 0 && pq[0].due == edge_no) begin
            t = pq[0];
            pq.delete(0);
            if (t.cull) begin
                if (m_cull < (1 << CW) - 1) m_cull++;
            end else if (mq.size() < DEPTH) begin
                mq.push_back(t);
            end else begin
                if (m_drop < (1 << CW) - 1) m_drop++;
                m_drop_pulse = 1'b1;
            end
        end
        if (rs) begin
            m_idx = vld ? 1 : 0;
            if (vld) m_v0 = pt;
        end else if (vld) begin
            if (m_idx == 0) begin
                m_v0 = pt; m_idx = 1;
            end else if (m_idx == 1) begin
                m_v1 = pt; m_idx = 2;
            end else begin
                pq.push_back(make_tri(m_v0, m_v1, pt));
                m_idx = 0;
            end
        end
    endtask

    task automatic cycle(input bit vld, input logic [38:0] pt, input bit rs, input bit rdy);
        check_outputs();
        rast_pt_valid = vld;
        rast_pt       = pt;
        prim_restart  = rs;
        tri_ready     = rdy;
        @(posedge clk);
        model_step(vld, pt, rs, rdy);
        @(negedge clk);
    endtask

    task automatic vert(input int x, input int y, input int z);
        cycle(1'b1, vtx(x, y, z), 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, 1'b0, rdy);
    endtask

    task automatic drain();
        repeat (8) idle(1'b1);
    endtask

    task automatic reset_cycle();
        rst = 1'b1; rast_pt_valid = 1'b0; prim_restart = 1'b0; tri_ready = 1'b0;
        @(posedge clk);
        edge_no++;
        mq.delete(); pq.delete();
        m_idx = 0; m_cull = 0; m_drop = 0; m_drop_pulse = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, tri_valid, 0);
        chk({tag, "_v0"}, tri_v0, 0);
        chk({tag, "_v1"}, tri_v1, 0);
        chk({tag, "_v2"}, tri_v2, 0);
        chk({tag, "_bbox"}, {tri_bb_min_x, tri_bb_min_y, tri_bb_max_x, tri_bb_max_y}, 0);
        chk({tag, "_area"}, tri_area2, 0);
        chk({tag, "_drop"}, tri_drop, 0);
        chk({tag, "_cull_cnt"}, cull_count, 0);
        chk({tag, "_drop_cnt"}, drop_count, 0);
    endtask

    function automatic int rc();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 8191)) - 4096;
        return int'($urandom_range(0, 100)) - 20;
    endfunction

    initial begin
        @(negedge clk);
        reset_cycle();
        check_all_zero("reset");

        // Basic triangle: latency and literal geometry.
        vert(10, 10, 5); vert(20, 10, 5); vert(10, 20, 5);
        idle(1'b0); idle(1'b0);
        chk("t1_latency_early", tri_valid, 0);
        idle(1'b0);
        chk("t1_valid", tri_valid, 1);
        chk("t1_area", tri_area2, 100);
        chk("t1_bbox", {tri_bb_min_x, tri_bb_min_y, tri_bb_max_x, tri_bb_max_y},
            {12'd10, 12'd10, 12'd20, 12'd20});
        chk("t1_v1", tri_v1, vtx(20, 10, 5));
        drain();

        // Clockwise winding.
        vert(10, 10, 5); vert(10, 20, 5); vert(20, 10, 5);
        repeat (3) idle(1'b0);
        if (BF == 1) begin
            chk("t2_cull_count", cull_count, 1);
            chk("t2_none", tri_valid, 0);
        end else begin
            chk("t2_v1_swapped", tri_v1, vtx(20, 10, 5));
            chk("t2_v2_swapped", tri_v2, vtx(10, 20, 5));
            chk("t2_area", tri_area2, 100);
        end
        drain();

        // Collinear, off-screen, and partially off-screen.
        vert(0, 0, 1); vert(5, 5, 1); vert(10, 10, 1);
        vert(-30, -30, 1); vert(-10, -30, 1); vert(-30, -10, 1);
        vert(-5, -5, 1); vert(70, 0, 1); vert(0, 70, 1);
        repeat (3) idle(1'b0);
        chk("t3_cull_count", cull_count, 2 + BF);
        chk("t3_valid", tri_valid, 1);
        chk("t3_bbox", {tri_bb_min_x, tri_bb_min_y, tri_bb_max_x, tri_bb_max_y},
            {12'd0, 12'd0, 12'd63, 12'd63});
        drain();

        // FIFO overflow with consumer stalled.
        for (int i = 0; i < 5; i++) begin
            vert(10, 10, i); vert(20, 10, i); vert(10, 20, i);
        end
        repeat (4) idle(1'b0);
        chk("t4_drop_count", drop_count, 1);
        chk("t4_head_z", tri_v0[38:26], 0);
        repeat (4) idle(1'b1);
        chk("t4_empty", tri_valid, 0);
        drain();

        // Restart with simultaneous vertex.
        vert(1, 1, 3); vert(40, 1, 3);
        cycle(1'b1, vtx(10, 10, 7), 1'b1, 1'b0);
        vert(20, 10, 7); vert(10, 20, 7);
        repeat (3) idle(1'b0);
        chk("t5_valid", tri_valid, 1);
        chk("t5_v0", tri_v0, vtx(10, 10, 7));
        chk("t5_area", tri_area2, 100);
        drain();

        // Reset while a triangle is in flight.
        vert(10, 10, 5); vert(20, 10, 5); vert(10, 20, 5);
        reset_cycle();
        check_all_zero("t6");
        repeat (6) idle(1'b1);

        // Randomized streams, second phase with a random screen size.
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                screen_w = 12'($urandom_range(1, 120));
                screen_h = 12'($urandom_range(1, 120));
            end
            for (int i = 0; i < 500; i++)
                cycle($urandom_range(0, 9) < 7, vtx(rc(), rc(), rc()),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
